// File: rtl/mem_ctrl_pkg.sv
// Shared request, size and state codes for the byte-serial memory controller.
// Imported by mem_ctrl and by anything that drives its request port.
package mem_ctrl_pkg;

  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] WRITE     = 2'd1;
  localparam logic [1:0] READ_DATA = 2'd2;
  localparam logic [1:0] READ_INST = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Instruction fetches always move a full word; the reserved size code also means word.
  function automatic int access_bytes(input logic [1:0] sig, input logic [1:0] size,
                                      input int word_bytes);
    if (sig == READ_INST) return word_bytes;
    case (size)
      SIZE_BYTE: return 1;
      SIZE_HALF: return 2;
      default:   return word_bytes;
    endcase
  endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache used by mem_ctrl when
// MEM_CTRL_ICACHE_EN is defined. All addresses here are word addresses (byte addr >> 2).
module icache_dm #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32,
  parameter int LINES      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-3:0] look_waddr_i,
  output logic                  look_hit_o,
  output logic [LEN-1:0]        look_data_o,
  input  logic                  fill_en_i,
  input  logic [ADDR_WIDTH-3:0] fill_waddr_i,
  input  logic [LEN-1:0]        fill_data_i,
  input  logic                  upd_en_i,
  input  logic [ADDR_WIDTH-3:0] upd_waddr_i,
  input  logic [LEN-1:0]        upd_data_i,
  input  logic                  inv_en_i,
  input  logic [ADDR_WIDTH-3:0] inv_lo_waddr_i,
  input  logic [ADDR_WIDTH-3:0] inv_hi_waddr_i
);
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WA_W - IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LEN-1:0]   data_q [LINES];

  logic [IDX_W-1:0] l_idx, f_idx, u_idx, lo_idx, hi_idx;
  logic [TAG_W-1:0] l_tag, f_tag, u_tag, lo_tag, hi_tag;

  assign l_idx  = look_waddr_i[IDX_W-1:0];
  assign l_tag  = look_waddr_i[WA_W-1:IDX_W];
  assign f_idx  = fill_waddr_i[IDX_W-1:0];
  assign f_tag  = fill_waddr_i[WA_W-1:IDX_W];
  assign u_idx  = upd_waddr_i[IDX_W-1:0];
  assign u_tag  = upd_waddr_i[WA_W-1:IDX_W];
  assign lo_idx = inv_lo_waddr_i[IDX_W-1:0];
  assign lo_tag = inv_lo_waddr_i[WA_W-1:IDX_W];
  assign hi_idx = inv_hi_waddr_i[IDX_W-1:0];
  assign hi_tag = inv_hi_waddr_i[WA_W-1:IDX_W];

  assign look_hit_o  = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign look_data_o = data_q[l_idx];

  // A partial write may straddle two words, so both touched lines are checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[f_idx] <= 1'b1;
    end else if (inv_en_i) begin
      if (valid_q[lo_idx] && (tag_q[lo_idx] == lo_tag)) valid_q[lo_idx] <= 1'b0;
      if (valid_q[hi_idx] && (tag_q[hi_idx] == hi_tag)) valid_q[hi_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[f_idx]  <= f_tag;
      data_q[f_idx] <= fill_data_i;
    end else if (upd_en_i && valid_q[u_idx] && (tag_q[u_idx] == u_tag)) begin
      data_q[u_idx] <= upd_data_i;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller turning CPU byte/half/word requests into one-byte
// memory cycles. Define MEM_CTRL_ICACHE_EN to add the direct-mapped instruction cache.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 17,
  parameter int LEN          = 32,
  parameter int BYTE_SIZE    = 8,
  parameter int ICACHE_LINES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mem_signal,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            mem_size,
  input  logic [LEN-1:0]        mem_write_data,
  output logic                  mem_ready,
  output logic                  mem_vis_finished,
  output logic [LEN-1:0]        mem_read_data,
  output logic [ADDR_WIDTH-1:0] mem_vis_addr,
  output logic                  mem_vis_signal,
  output logic [BYTE_SIZE-1:0]  writen_data,
  input  logic [BYTE_SIZE-1:0]  mem_data
);
  localparam int NBYTES = LEN / BYTE_SIZE;
  localparam int CNT_W  = $clog2(NBYTES + 1);

  if (ICACHE_LINES < 1 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two");
  end

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, nbytes_q, req_n;
  logic [LEN-1:0]        wshift_q, rbuf_q, rbuf_d, rdata_q, hit_data;
  logic [ADDR_WIDTH-1:0] vis_addr_q;
  logic                  vis_sig_q;
  logic [BYTE_SIZE-1:0]  wbyte_q;
  logic                  accept, hit, last_rd, last_wr;

  assign req_n   = CNT_W'(access_bytes(mem_signal, mem_size, NBYTES));
  assign accept  = (state_q == ST_IDLE) && (mem_signal != MEM_NOP);
  assign last_rd = (cnt_q == nbytes_q);
  assign last_wr = ((cnt_q + CNT_W'(1)) == nbytes_q);

  // Memory data lags its address by one cycle, so byte k lands while cnt_q == k+1.
  always_comb begin
    rbuf_d = rbuf_q;
    for (int i = 0; i < NBYTES; i++)
      if (state_q == ST_READ && int'(cnt_q) == i + 1)
        rbuf_d[i*BYTE_SIZE +: BYTE_SIZE] = mem_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = hit ? ST_DONE : ((mem_signal == WRITE) ? ST_WRITE : ST_READ);
      ST_READ:  if (last_rd) state_d = ST_DONE;
      ST_WRITE: if (last_wr) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      wshift_q   <= '0;
      rbuf_q     <= '0;
      rdata_q    <= '0;
      vis_addr_q <= '0;
      vis_sig_q  <= 1'b0;
      wbyte_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (accept) begin
          if (hit) begin
            rdata_q <= hit_data;
          end else begin
            cnt_q      <= '0;
            nbytes_q   <= req_n;
            vis_addr_q <= addr;
            rbuf_q     <= '0;
            if (mem_signal == WRITE) begin
              vis_sig_q <= 1'b1;
              wbyte_q   <= mem_write_data[BYTE_SIZE-1:0];
              wshift_q  <= mem_write_data >> BYTE_SIZE;
            end
          end
        end
        // The extra READ cycle after the last address only waits for its data.
        ST_READ: begin
          rbuf_q <= rbuf_d;
          if (last_rd) begin
            rdata_q <= rbuf_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if ((cnt_q + CNT_W'(1)) < nbytes_q) vis_addr_q <= vis_addr_q + ADDR_WIDTH'(1);
          end
        end
        ST_WRITE: begin
          if (last_wr) begin
            vis_sig_q <= 1'b0;
          end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
            vis_addr_q <= vis_addr_q + ADDR_WIDTH'(1);
            wbyte_q    <= wshift_q[BYTE_SIZE-1:0];
            wshift_q   <= wshift_q >> BYTE_SIZE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_CTRL_ICACHE_EN
  logic [ADDR_WIDTH-3:0] base_waddr_q, last_waddr;
  logic                  fill_q, look_hit, word_wr;

  assign word_wr    = (req_n == CNT_W'(NBYTES)) && (addr[1:0] == 2'b00);
  assign last_waddr = (ADDR_WIDTH-2)'((addr + ADDR_WIDTH'(req_n) - ADDR_WIDTH'(1)) >> 2);
  assign hit        = (mem_signal == READ_INST) && (addr[1:0] == 2'b00) && look_hit;

  // Only word-aligned fetches are cacheable; remember that and the line for the fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_waddr_q <= '0;
      fill_q       <= 1'b0;
    end else if (accept) begin
      base_waddr_q <= addr[ADDR_WIDTH-1:2];
      fill_q       <= (mem_signal == READ_INST) && (addr[1:0] == 2'b00);
    end
  end

  icache_dm #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN       (LEN),
    .LINES     (ICACHE_LINES)
  ) u_icache (
    .clk           (clk),
    .rst_n         (rst_n),
    .look_waddr_i  (addr[ADDR_WIDTH-1:2]),
    .look_hit_o    (look_hit),
    .look_data_o   (hit_data),
    .fill_en_i     ((state_q == ST_READ) && last_rd && fill_q),
    .fill_waddr_i  (base_waddr_q),
    .fill_data_i   (rbuf_d),
    .upd_en_i      (accept && (mem_signal == WRITE) && word_wr),
    .upd_waddr_i   (addr[ADDR_WIDTH-1:2]),
    .upd_data_i    (mem_write_data),
    .inv_en_i      (accept && (mem_signal == WRITE) && !word_wr),
    .inv_lo_waddr_i(addr[ADDR_WIDTH-1:2]),
    .inv_hi_waddr_i(last_waddr)
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  assign mem_ready        = (state_q == ST_IDLE);
  assign mem_vis_finished = (state_q == ST_DONE);
  assign mem_read_data    = rdata_q;
  assign mem_vis_addr     = vis_addr_q;
  assign mem_vis_signal   = vis_sig_q;
  assign writen_data      = wbyte_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a one-cycle-latency byte memory model.
// Cache-dependent latencies follow MEM_CTRL_ICACHE_EN.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

`ifdef MEM_CTRL_ICACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 6;
`endif

  logic        clk, rst_n;
  logic [1:0]  mem_signal, mem_size;
  logic [16:0] addr;
  logic [31:0] mem_write_data;
  logic        mem_ready, mem_vis_finished, mem_vis_signal;
  logic [31:0] mem_read_data;
  logic [16:0] mem_vis_addr;
  logic [7:0]  writen_data, mem_data;

  logic [7:0]  mem [0:(1<<17)-1];
  logic        pokeEn;
  logic [16:0] pokeAddr;
  logic [7:0]  pokeData;

  int          checks, failures;
  int          lat, wrCount, extra;
  logic [31:0] rdData;
  logic [16:0] wrAddr [4];
  logic [7:0]  wrData [4];
  bit          addrMoved, readySeen, sawFinish;

  mem_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_signal      (mem_signal),
    .addr            (addr),
    .mem_size        (mem_size),
    .mem_write_data  (mem_write_data),
    .mem_ready       (mem_ready),
    .mem_vis_finished(mem_vis_finished),
    .mem_read_data   (mem_read_data),
    .mem_vis_addr    (mem_vis_addr),
    .mem_vis_signal  (mem_vis_signal),
    .writen_data     (writen_data),
    .mem_data        (mem_data)
  );

  always #5 clk = ~clk;

  // Byte memory: registered read, write on the edge while mem_vis_signal is high.
  always @(posedge clk) begin
    if (pokeEn) mem[pokeAddr] <= pokeData;
    else if (mem_vis_signal) mem[mem_vis_addr] <= writen_data;
    mem_data <= mem[mem_vis_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pokeByte(input logic [16:0] a, input logic [7:0] d);
    pokeAddr = a;
    pokeData = d;
    pokeEn   = 1'b1;
    @(posedge clk);
    #1 pokeEn = 1'b0;
  endtask

  // Issues one request and records latency (cycles after the accept edge), read data,
  // the write bytes seen and whether mem_vis_addr moved before the response.
  task automatic applyStimulus(input logic [1:0] sig, input logic [16:0] a, input logic [1:0] sz,
                               input logic [31:0] wd, input bit toggle);
    logic [16:0] preAddr;
    int guard;
    guard = 0;
    @(negedge clk);
    while (mem_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_before_req", {31'd0, mem_ready}, 32'd1);
    preAddr        = mem_vis_addr;
    mem_signal     = sig;
    addr           = a;
    mem_size       = sz;
    mem_write_data = wd;
    @(posedge clk);
    #1;
    mem_signal = toggle ? READ_DATA : MEM_NOP;
    addr       = 17'h0ABCD;
    lat        = 99;
    rdData     = 32'hXXXXXXXX;
    wrCount    = 0;
    addrMoved  = 1'b0;
    readySeen  = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_vis_addr !== preAddr) addrMoved = 1'b1;
      if (mem_ready === 1'b1) readySeen = 1'b1;
      if (mem_vis_signal === 1'b1) begin
        if (wrCount < 4) begin
          wrAddr[wrCount] = mem_vis_addr;
          wrData[wrCount] = writen_data;
        end
        wrCount++;
      end
      if (toggle) mem_signal = (c % 2 == 1) ? WRITE : READ_INST;
      if (mem_vis_finished === 1'b1) begin
        lat    = c;
        rdData = mem_read_data;
        break;
      end
    end
    mem_signal = MEM_NOP;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b1; pokeEn = 1'b0; pokeAddr = '0; pokeData = '0;
    mem_signal = MEM_NOP; addr = '0; mem_size = SIZE_BYTE; mem_write_data = '0;
    checks = 0; failures = 0;
    $display("[TB] mem_ctrl directed test start");

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", {31'd0, mem_ready}, 32'd1);
    checkOutput("rst_finished", {31'd0, mem_vis_finished}, 32'd0);
    checkOutput("rst_read_data", mem_read_data, 32'd0);
    checkOutput("rst_vis_addr", {15'd0, mem_vis_addr}, 32'd0);
    checkOutput("rst_vis_signal", {31'd0, mem_vis_signal}, 32'd0);
    checkOutput("rst_writen_data", {24'd0, writen_data}, 32'd0);

    pokeByte(17'h00010, 8'h11); pokeByte(17'h00011, 8'h22);
    pokeByte(17'h00012, 8'h33); pokeByte(17'h00013, 8'h44);
    pokeByte(17'h00100, 8'h01); pokeByte(17'h00101, 8'h02);
    pokeByte(17'h00102, 8'h03); pokeByte(17'h00103, 8'h04);
    pokeByte(17'h00104, 8'h55); pokeByte(17'h00105, 8'h66);
    @(negedge clk) rst_n = 1'b1;

    applyStimulus(READ_DATA, 17'h00010, SIZE_WORD, 32'd0, 1'b0);
    checkOutput("rd_word_lat", lat, 32'd6);
    checkOutput("rd_word_data", rdData, 32'h44332211);
    checkOutput("rd_word_busy", {31'd0, readySeen}, 32'd0);

    applyStimulus(WRITE, 17'h1FFFF, SIZE_BYTE, 32'h000000A5, 1'b0);
    checkOutput("wr_byte_lat", lat, 32'd2);
    checkOutput("wr_byte_count", wrCount, 32'd1);
    checkOutput("wr_byte_addr", {15'd0, wrAddr[0]}, 32'h1FFFF);
    checkOutput("wr_byte_data", {24'd0, wrData[0]}, 32'hA5);
    checkOutput("rd_data_held", mem_read_data, 32'h44332211);

    applyStimulus(WRITE, 17'h1FFFF, SIZE_HALF, 32'h11225AC3, 1'b0);
    checkOutput("wr_half_lat", lat, 32'd3);
    checkOutput("wr_half_count", wrCount, 32'd2);
    checkOutput("wr_half_addr0", {15'd0, wrAddr[0]}, 32'h1FFFF);
    checkOutput("wr_half_addr1", {15'd0, wrAddr[1]}, 32'h00000);
    checkOutput("wr_half_data1", {24'd0, wrData[1]}, 32'h5A);

    applyStimulus(READ_DATA, 17'h1FFFF, SIZE_HALF, 32'd0, 1'b0);
    checkOutput("rd_half_wrap_lat", lat, 32'd4);
    checkOutput("rd_half_wrap_data", rdData, 32'h00005AC3);

    applyStimulus(READ_DATA, 17'h00011, SIZE_BYTE, 32'd0, 1'b0);
    checkOutput("rd_byte_lat", lat, 32'd3);
    checkOutput("rd_byte_data", rdData, 32'h00000022);

    applyStimulus(READ_INST, 17'h00100, SIZE_BYTE, 32'd0, 1'b0);
    checkOutput("inst_miss_lat", lat, 32'd6);
    checkOutput("inst_miss_data", rdData, 32'h04030201);

    applyStimulus(READ_INST, 17'h00100, SIZE_BYTE, 32'd0, 1'b0);
    checkOutput("inst_again_lat", lat, HIT_LAT);
    checkOutput("inst_again_data", rdData, 32'h04030201);
`ifdef MEM_CTRL_ICACHE_EN
    checkOutput("inst_hit_no_addr", {31'd0, addrMoved}, 32'd0);
`endif

    applyStimulus(WRITE, 17'h00100, SIZE_WORD, 32'hDEADBEEF, 1'b0);
    checkOutput("wr_word_lat", lat, 32'd5);
    applyStimulus(READ_INST, 17'h00100, SIZE_WORD, 32'd0, 1'b0);
    checkOutput("inst_upd_lat", lat, HIT_LAT);
    checkOutput("inst_upd_data", rdData, 32'hDEADBEEF);

    applyStimulus(WRITE, 17'h00101, SIZE_BYTE, 32'h00000077, 1'b0);
    applyStimulus(READ_INST, 17'h00100, SIZE_BYTE, 32'd0, 1'b0);
    checkOutput("inst_inv_lat", lat, 32'd6);
    checkOutput("inst_inv_data", rdData, 32'hDEAD77EF);

    applyStimulus(READ_INST, 17'h00102, SIZE_BYTE, 32'd0, 1'b0);
    checkOutput("inst_unal_data", rdData, 32'h6655DEAD);
    applyStimulus(READ_INST, 17'h00102, SIZE_BYTE, 32'd0, 1'b0);
    checkOutput("inst_unal_lat", lat, 32'd6);

    applyStimulus(READ_DATA, 17'h00010, SIZE_WORD, 32'd0, 1'b1);
    checkOutput("toggle_lat", lat, 32'd6);
    checkOutput("toggle_data", rdData, 32'h44332211);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_vis_finished !== 1'b0) extra++;
    end
    checkOutput("toggle_no_extra", extra, 32'd0);
    checkOutput("toggle_ready_after", {31'd0, mem_ready}, 32'd1);

    @(negedge clk);
    mem_signal = WRITE; addr = 17'h00200; mem_size = SIZE_WORD; mem_write_data = 32'h12345678;
    @(posedge clk);
    #1 mem_signal = MEM_NOP;
    repeat (3) @(negedge clk);
    checkOutput("abort_wr_active", {31'd0, mem_vis_signal}, 32'd1);
    checkOutput("abort_wr_addr", {15'd0, mem_vis_addr}, 32'h00202);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_vis_signal", {31'd0, mem_vis_signal}, 32'd0);
    checkOutput("abort_ready", {31'd0, mem_ready}, 32'd1);
    checkOutput("abort_finished", {31'd0, mem_vis_finished}, 32'd0);
    checkOutput("abort_vis_addr", {15'd0, mem_vis_addr}, 32'd0);
    sawFinish = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (mem_vis_finished !== 1'b0) sawFinish = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_vis_finished !== 1'b0) sawFinish = 1'b1;
    end
    checkOutput("abort_no_response", {31'd0, sawFinish}, 32'd0);

    applyStimulus(READ_INST, 17'h00100, SIZE_BYTE, 32'd0, 1'b0);
    checkOutput("post_rst_inst_lat", lat, 32'd6);
    checkOutput("post_rst_inst_data", rdData, 32'hDEAD77EF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
